barrel_shift_pipe: RTL and testbench

Parametrised, handshaked barrel shifter for the ALU datapath. Supports logical left/right, arithmetic right and both rotates, selected per transaction. Also produces carry-out and zero flags. Built as log2(NBITS) mux levels; the levels are either registered individually (pipelined) or collapsed into one output register. Sits between operand issue and ALU result writeback, and replaces the fixed-width combinational left-shift unit.

---
 rtl/barrel_shift_pipe_pkg.sv | 42 ++++
 rtl/barrel_shift_pipe_if.sv | 29 ++
 rtl/barrel_shift_pipe_shift_level.sv | 97 +++++++++
 rtl/barrel_shift_pipe.sv | 65 ++++++
 tb/tb_barrel_shift_pipe.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/barrel_shift_pipe_pkg.sv
// Shared types and helpers for the barrel shifter: op encoding and the carry-out rule.
// Consumed by shift_level and barrel_shift_pipe via import shifter_pkg::*.
package shifter_pkg;

    typedef enum logic [2:0] {
        OP_SLL  = 3'b000,
        OP_SRL  = 3'b001,
        OP_SRA  = 3'b010,
        OP_ROL  = 3'b011,
        OP_ROR  = 3'b100,
        OP_PASS = 3'b111
    } shift_op_e;

    localparam int MAX_NBITS = 64;

    // Carry is the last bit leaving the operand; rotates report the bit that wrapped,
    // which is the same source bit as the matching logical shift.
    function automatic logic shift_carry(input logic [MAX_NBITS-1:0] a,
                                         input int unsigned shamt,
                                         input shift_op_e op,
                                         input int unsigned nbits);
        logic       c;
        logic [5:0] idx;
        c   = 1'b0;
        idx = '0;
        if (shamt != 0) begin
            case (op)
                OP_SLL, OP_ROL: begin
                    idx = 6'(nbits - shamt);
                    c   = a[idx];
                end
                OP_SRL, OP_SRA, OP_ROR: begin
                    idx = 6'(shamt - 1);
                    c   = a[idx];
                end
                default: c = 1'b0;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/barrel_shift_pipe_if.sv
// Operand/result bus of the barrel shifter. The slave modport is the shifter side,
// the master modport is the issuing/consuming side.
interface barrel_shift_pipe_if #(parameter int NBITS = 8);
    localparam int SW = $clog2(NBITS);

    // Both channels are valid/ready: a beat transfers on a clock edge where valid && ready;
    // valid never waits on ready, and payload holds steady while valid && !ready.
    logic             in_valid;
    logic             in_ready;
    logic [NBITS-1:0] a;
    logic [SW-1:0]    shamt;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [NBITS-1:0] out;
    logic             carry;
    logic             zero;

    modport master (
        output in_valid, a, shamt, op, out_ready,
        input  in_ready, out_valid, out, carry, zero
    );

    modport slave (
        input  in_valid, a, shamt, op, out_ready,
        output in_ready, out_valid, out, carry, zero
    );

endinterface

// File: rtl/barrel_shift_pipe_shift_level.sv
// One mux level of the barrel shifter: shifts by 2^LEVEL_IDX when its shamt bit is set.
// SHIFTER_PIPE_EN: every level registers; otherwise only the last level does.
module shift_level
    import shifter_pkg::*;
#(
    parameter int NBITS     = 8,
    parameter int LEVEL_IDX = 0,
    localparam int SW       = $clog2(NBITS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [NBITS-1:0] up_data,
    input  logic [SW-1:0]    up_shamt,
    input  shift_op_e        up_op,
    input  logic             up_carry,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [NBITS-1:0] dn_data,
    output logic [SW-1:0]    dn_shamt,
    output shift_op_e        dn_op,
    output logic             dn_carry
);

    localparam int DIST   = 1 << LEVEL_IDX;
    localparam int LEVELS = $clog2(NBITS);

`ifdef SHIFTER_PIPE_EN
    localparam bit HAS_REG = 1'b1;
`else
    localparam bit HAS_REG = (LEVEL_IDX == LEVELS - 1);
`endif

    logic [NBITS-1:0] shifted;

    always_comb begin
        shifted = up_data;
        if (up_shamt[LEVEL_IDX]) begin
            case (up_op)
                OP_SLL:  shifted = up_data << DIST;
                OP_SRL:  shifted = up_data >> DIST;
                OP_SRA:  shifted = NBITS'($signed(up_data) >>> DIST);
                OP_ROL:  shifted = (up_data << DIST) | (up_data >> (NBITS - DIST));
                OP_ROR:  shifted = (up_data >> DIST) | (up_data << (NBITS - DIST));
                default: shifted = up_data;
            endcase
        end
    end

    generate
        if (HAS_REG) begin : g_reg
            logic             v_q;
            logic [NBITS-1:0] d_q;
            logic [SW-1:0]    s_q;
            shift_op_e        o_q;
            logic             c_q;

            // An empty slot or a draining successor lets the stage take a new beat.
            assign up_ready = !v_q || dn_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                    d_q <= '0;
                    s_q <= '0;
                    o_q <= OP_SLL;
                    c_q <= 1'b0;
                end else if (up_ready) begin
                    v_q <= up_valid;
                    if (up_valid) begin
                        d_q <= shifted;
                        s_q <= up_shamt;
                        o_q <= up_op;
                        c_q <= up_carry;
                    end
                end
            end

            assign dn_valid = v_q;
            assign dn_data  = d_q;
            assign dn_shamt = s_q;
            assign dn_op    = o_q;
            assign dn_carry = c_q;
        end else begin : g_comb
            logic unused_clk;
            assign unused_clk = clk ^ rst_n;
            assign up_ready   = dn_ready;
            assign dn_valid   = up_valid;
            assign dn_data    = shifted;
            assign dn_shamt   = up_shamt;
            assign dn_op      = up_op;
            assign dn_carry   = up_carry;
        end
    endgenerate

endmodule

// File: rtl/barrel_shift_pipe.sv
// Handshaked barrel shifter (SLL/SRL/SRA/ROL/ROR/PASS) with carry and zero flags.
// Define SHIFTER_PIPE_EN to register every mux level; default is one output register.
module barrel_shift_pipe
    import shifter_pkg::*;
#(
    parameter int NBITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    barrel_shift_pipe_if.slave  bus
);

    localparam int SW     = $clog2(NBITS);
    localparam int LEVELS = $clog2(NBITS);

    logic             vld [LEVELS+1];
    logic             rdy [LEVELS+1];
    logic [NBITS-1:0] dat [LEVELS+1];
    logic [SW-1:0]    sha [LEVELS+1];
    shift_op_e        opc [LEVELS+1];
    logic             cry [LEVELS+1];

    // Carry depends on the untouched operand, so it is resolved once at entry and travels along.
    assign vld[0]       = bus.in_valid;
    assign dat[0]       = bus.a;
    assign sha[0]       = bus.shamt;
    assign opc[0]       = shift_op_e'(bus.op);
    assign cry[0]       = shift_carry(64'(bus.a), 32'(bus.shamt), shift_op_e'(bus.op), NBITS);
    assign bus.in_ready = rdy[0];

    generate
        for (genvar i = 0; i < LEVELS; i++) begin : g_level
            shift_level #(
                .NBITS     (NBITS),
                .LEVEL_IDX (i)
            ) u_level (
                .clk      (clk),
                .rst_n    (rst_n),
                .up_valid (vld[i]),
                .up_ready (rdy[i]),
                .up_data  (dat[i]),
                .up_shamt (sha[i]),
                .up_op    (opc[i]),
                .up_carry (cry[i]),
                .dn_valid (vld[i+1]),
                .dn_ready (rdy[i+1]),
                .dn_data  (dat[i+1]),
                .dn_shamt (sha[i+1]),
                .dn_op    (opc[i+1]),
                .dn_carry (cry[i+1])
            );
        end
    endgenerate

    assign rdy[LEVELS]   = bus.out_ready;
    assign bus.out_valid = vld[LEVELS];
    assign bus.out       = dat[LEVELS];
    assign bus.carry     = cry[LEVELS];
    // Gated by valid so the flag reads 0 out of reset and while idle.
    assign bus.zero      = vld[LEVELS] && (dat[LEVELS] == '0);

    logic unused_tail;
    assign unused_tail = ^{sha[LEVELS], opc[LEVELS]};

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Bench for barrel_shift_pipe: directed vectors, random stream with random back-pressure,
// stall/throughput and mid-flight reset, all scored against an arithmetic reference model.
module tb_barrel_shift_pipe;

    localparam int NBITS = 8;
    localparam int SW    = $clog2(NBITS);
    localparam int W     = NBITS + 1;
`ifdef SHIFTER_PIPE_EN
    localparam int LAT = $clog2(NBITS);
`else
    localparam int LAT = 1;
`endif
    localparam int CAP = LAT;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_bad;
    int   n_in;
    int   n_out;
    int   rdy_mode;
    bit   chk_rdy;
    logic [W-1:0] exp_q[$];

    barrel_shift_pipe_if #(.NBITS(NBITS)) bus ();

    barrel_shift_pipe #(.NBITS(NBITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: shift inside a double-width word and read the bit just past the result.
    function automatic logic [W-1:0] ref_model(input logic [NBITS-1:0] a,
                                               input logic [SW-1:0] sh,
                                               input logic [2:0] op);
        logic [2*NBITS-1:0] w;
        logic [NBITS-1:0]   r;
        logic               c;
        w = '0;
        r = a;
        c = 1'b0;
        case (op)
            3'd0: begin
                w = {{NBITS{1'b0}}, a} << sh;
                r = w[NBITS-1:0];
                c = (sh != 0) ? w[NBITS] : 1'b0;
            end
            3'd1: begin
                w = {a, {NBITS{1'b0}}} >> sh;
                r = w[2*NBITS-1:NBITS];
                c = (sh != 0) ? w[NBITS-1] : 1'b0;
            end
            3'd2: begin
                w = {a, {NBITS{1'b0}}};
                w = $signed(w) >>> sh;
                r = w[2*NBITS-1:NBITS];
                c = (sh != 0) ? w[NBITS-1] : 1'b0;
            end
            3'd3: begin
                w = {a, a} << sh;
                r = w[2*NBITS-1:NBITS];
                c = (sh != 0) ? r[0] : 1'b0;
            end
            3'd4: begin
                w = {a, a} >> sh;
                r = w[NBITS-1:0];
                c = (sh != 0) ? r[NBITS-1] : 1'b0;
            end
            default: begin
                r = a;
                c = 1'b0;
            end
        endcase
        return {c, r};
    endfunction

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (chk_rdy)
                check_eq("in_ready_rule", bus.in_ready,
                         !(((n_in - n_out) == CAP) && !bus.out_ready));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out", bus.out_valid, 1'b0);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    check_eq("out", bus.out, e[NBITS-1:0]);
                    check_eq("carry", bus.carry, e[NBITS]);
                    check_eq("zero", bus.zero, e[NBITS-1:0] == '0);
                end
                n_out++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_model(bus.a, bus.shamt, bus.op));
                n_in++;
            end
        end
    end

    // ---------------- drivers ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    task automatic set_rdy(input int m);
        rdy_mode      = m;
        bus.out_ready = (m == 0);
    endtask

    task automatic rand_inputs();
        bus.a     = NBITS'($urandom);
        bus.shamt = SW'($urandom_range(0, NBITS - 1));
        bus.op    = 3'($urandom_range(0, 7));
    endtask

    task automatic send(input logic [NBITS-1:0] a, input logic [SW-1:0] sh, input logic [2:0] op);
        bit fired;
        fired        = 1'b0;
        bus.a        = a;
        bus.shamt    = sh;
        bus.op       = op;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !fired; i++) begin
            @(negedge clk);
            fired = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        check_eq("send_accepted", fired, 1'b1);
    endtask

    task automatic run_vec(input logic [NBITS-1:0] a, input logic [SW-1:0] sh, input logic [2:0] op,
                           input logic [NBITS-1:0] e_out, input logic e_c, input logic e_z);
        set_rdy(0);
        send(a, sh, op);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            check_eq("latency_valid", bus.out_valid, k == LAT);
            if (k == LAT) begin
                check_eq("vec_out", bus.out, e_out);
                check_eq("vec_carry", bus.carry, e_c);
                check_eq("vec_zero", bus.zero, e_z);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Hold in_valid high, presenting a fresh random operand after every accepted beat.
    task automatic stream(input int n);
        int  cnt;
        int  cyc;
        bit  fired;
        cnt          = 0;
        cyc          = 0;
        rand_inputs();
        bus.in_valid = 1'b1;
        while (cnt < n && cyc < 1000) begin
            @(negedge clk);
            fired = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (fired) begin
                cnt++;
                rand_inputs();
            end
        end
        bus.in_valid = 1'b0;
        check_eq("stream_count", cnt, n);
    endtask

    task automatic drain();
        set_rdy(0);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("drain_empty", exp_q.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n0;
        n_checks      = 0;
        n_bad         = 0;
        n_in          = 0;
        n_out         = 0;
        rdy_mode      = 0;
        chk_rdy       = 1'b0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.shamt     = '0;
        bus.op        = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        @(negedge clk);
        check_eq("rst_out_valid", bus.out_valid, 1'b0);
        check_eq("rst_out", bus.out, '0);
        check_eq("rst_carry", bus.carry, 1'b0);
        check_eq("rst_zero", bus.zero, 1'b0);
        check_eq("rst_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        chk_rdy = 1'b1;

        run_vec(8'h96, 3'd3, 3'b010, 8'hF2, 1'b1, 1'b0);
        run_vec(8'h81, 3'd1, 3'b000, 8'h02, 1'b1, 1'b0);
        run_vec(8'h01, 3'd1, 3'b100, 8'h80, 1'b1, 1'b0);
        run_vec(8'h80, 3'd1, 3'b011, 8'h01, 1'b1, 1'b0);
        run_vec(8'h0F, 3'd4, 3'b001, 8'h00, 1'b1, 1'b1);
        run_vec(8'h5A, 3'd5, 3'b111, 8'h5A, 1'b0, 1'b0);
        run_vec(8'hFF, 3'd0, 3'b000, 8'hFF, 1'b0, 1'b0);
        run_vec(8'h01, 3'd7, 3'b011, 8'h80, 1'b0, 1'b0);
        run_vec(8'h80, 3'd7, 3'b100, 8'h01, 1'b0, 1'b0);
        run_vec(8'h80, 3'd7, 3'b010, 8'hFF, 1'b0, 1'b0);
        run_vec(8'h3C, 3'd0, 3'b101, 8'h3C, 1'b0, 1'b0);

        // Random stream under 50% back-pressure.
        set_rdy(1);
        stream(20);
        drain();

        // Fill with the output blocked, then verify the held result.
        set_rdy(2);
        n0 = n_in;
        rand_inputs();
        bus.in_valid = 1'b1;
        repeat (CAP + 2) begin
            @(negedge clk);
            @(posedge clk);
            #1;
            rand_inputs();
        end
        check_eq("fill_count", n_in - n0, CAP);
        check_eq("full_in_ready", bus.in_ready, 1'b0);
        repeat (5) begin
            @(negedge clk);
            check_eq("stall_valid", bus.out_valid, 1'b1);
            check_eq("stall_out", bus.out, exp_q[0][NBITS-1:0]);
            check_eq("stall_carry", bus.carry, exp_q[0][NBITS]);
            check_eq("stall_zero", bus.zero, exp_q[0][NBITS-1:0] == '0);
        end
        @(posedge clk);
        #1;
        // Release with input still pending: one result per cycle.
        set_rdy(0);
        n0 = n_out;
        repeat (6) begin
            @(negedge clk);
            @(posedge clk);
            #1;
            rand_inputs();
        end
        check_eq("throughput", n_out - n0, 6);
        bus.in_valid = 1'b0;
        drain();

        // Reset with work in flight.
        set_rdy(2);
        rand_inputs();
        bus.in_valid = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            rand_inputs();
        end
        bus.in_valid = 1'b0;
        chk_rdy      = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", bus.out_valid, 1'b0);
        check_eq("midrst_out", bus.out, '0);
        check_eq("midrst_carry", bus.carry, 1'b0);
        check_eq("midrst_zero", bus.zero, 1'b0);
        exp_q.delete();
        n_in  = 0;
        n_out = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        set_rdy(0);
        check_eq("post_rst_in_ready", bus.in_ready, 1'b1);
        chk_rdy = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_eq("no_stale", bus.out_valid, 1'b0);
        end
        @(posedge clk);
        #1;

        // Short random stream after reset to confirm normal operation resumes.
        set_rdy(1);
        stream(10);
        drain();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
